// File: rtl/clks_pkg.sv
// Shared definitions for the clks divider controller: source encodings,
// controller states and legal parameter ranges.
package clks_pkg;

  localparam logic [1:0] SEL_CLK10   = 2'd0;
  localparam logic [1:0] SEL_CLK20   = 2'd1;
  localparam logic [1:0] SEL_CLK40   = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    SWITCH = 3'd4
  } state_t;

  // Legal ranges for the controller parameters; the counter is 8 bits wide.
  localparam int CNT_W            = 8;
  localparam int RST_CYCLES_MIN   = 1;
  localparam int RST_CYCLES_MAX   = 255;
  localparam int SETTLE_EDGES_MIN = 1;
  localparam int SETTLE_EDGES_MAX = 15;
  localparam int SW_TIMEOUT_MIN   = 41;
  localparam int SW_TIMEOUT_MAX   = 255;

  // Sample of the divided clock addressed by sel; the illegal code reads as 0.
  function automatic logic pick_src(input logic [1:0] sel, input logic c10,
                                    input logic c20, input logic c40);
    logic v;
    case (sel)
      SEL_CLK10: v = c10;
      SEL_CLK20: v = c20;
      SEL_CLK40: v = c40;
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/clks_glitchless_mux.sv
// Output stage of the clock selector: registers the currently selected
// divided clock (or 0 when forced) and reports whether the old and the
// target sources are presently low.
module clks_glitchless_mux
  import clks_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk10,
  input  logic       clk20,
  input  logic       clk40,
  input  logic [1:0] cur_sel,
  input  logic [1:0] target,
  input  logic       force_low,
  output logic       clk_out,
  output logic       old_low,
  output logic       target_low
);

  assign old_low    = !pick_src(cur_sel, clk10, clk20, clk40);
  assign target_low = !pick_src(target, clk10, clk20, clk40);

  // Output register: follow the current source one cycle late unless held low
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out <= 1'b0;
    end else begin
      clk_out <= force_low ? 1'b0 : pick_src(cur_sel, clk10, clk20, clk40);
    end
  end

endmodule

// File: rtl/clks_ctrl.sv
// Lifecycle sequencer for the clks divider (reset hold, enable, settle,
// run, stop) plus glitch-free selection of the divided clock on clk_out.
module clks_ctrl
  import clks_pkg::*;
#(
  parameter int RST_CYCLES   = 8,
  parameter int SETTLE_EDGES = 2,
  parameter int SW_TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] sel_req,
  input  logic       sel_valid,
  output logic       sel_ack,
  input  logic       clk10,
  input  logic       clk20,
  input  logic       clk40,
  output logic       clks_rst,
  output logic       clks_enb,
  output logic       clk_out,
  output logic       ready,
  output logic       busy,
  output logic       err,
  output logic [1:0] cur_sel
);

  generate
    if (RST_CYCLES < RST_CYCLES_MIN || RST_CYCLES > RST_CYCLES_MAX ||
        SETTLE_EDGES < SETTLE_EDGES_MIN || SETTLE_EDGES > SETTLE_EDGES_MAX ||
        SW_TIMEOUT < SW_TIMEOUT_MIN || SW_TIMEOUT > SW_TIMEOUT_MAX) begin : g_bad_params
      $error("clks_ctrl: parameter out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EDGES - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_TIMEOUT - 1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ph_b, ph_b_nxt;          // SWITCH: 0 = follow old source, 1 = held low
  logic             hold_low, hold_low_nxt;  // RUN: wait for source low after an aborted switch
  logic [1:0]       target, target_nxt;
  logic [1:0]       cur_sel_nxt;
  logic             sel_ack_nxt, err_nxt;
  logic             clk40_p0;
  logic             clk40_rise;
  logic             req_live;
  logic             force_low;
  logic             old_low, target_low;

  assign clk40_rise = clk40 & ~clk40_p0;
  assign req_live   = sel_valid & ~sel_ack & ~hold_low;

  assign clks_rst = (state == IDLE) || (state == HOLD);
  assign clks_enb = (state == SETTLE) || (state == RUN) || (state == SWITCH);
  assign ready    = (state == RUN) || (state == SWITCH);
  assign busy     = (state == SWITCH);

  // clk_out is held low outside RUN/SWITCH, while waiting for the target,
  // and while resynchronising to the old source after an aborted switch.
  assign force_low = ((state_nxt != RUN) && (state_nxt != SWITCH)) ||
                     ((state == SWITCH) && ph_b) || hold_low;

  // Next-state, counter and handshake decisions
  always_comb begin
    state_nxt    = state;
    ph_b_nxt     = ph_b;
    hold_low_nxt = hold_low;
    target_nxt   = target;
    cur_sel_nxt  = cur_sel;
    sel_ack_nxt  = 1'b0;
    err_nxt      = 1'b0;
    cnt_nxt      = cnt;

    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = HOLD;
      end
      HOLD: begin
        if (stop)                 state_nxt = IDLE;
        else if (cnt == RST_LAST) state_nxt = SETTLE;
        cnt_nxt = sat_inc(cnt);
      end
      SETTLE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (clk40_rise) begin
          if (cnt == SETTLE_LAST) state_nxt = RUN;
          cnt_nxt = sat_inc(cnt);
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt    = IDLE;
          hold_low_nxt = 1'b0;
        end else begin
          if (hold_low && old_low) hold_low_nxt = 1'b0;
          if (req_live) begin
            if (sel_req == SEL_ILLEGAL) begin
              sel_ack_nxt = 1'b1;
              err_nxt     = 1'b1;
            end else if (sel_req == cur_sel) begin
              sel_ack_nxt = 1'b1;
            end else begin
              target_nxt = sel_req;
              state_nxt  = SWITCH;
            end
          end
        end
      end
      SWITCH: begin
        cnt_nxt = sat_inc(cnt);
        if (stop) begin
          state_nxt = IDLE;
        end else if (ph_b && target_low) begin
          cur_sel_nxt = target;
          sel_ack_nxt = 1'b1;
          state_nxt   = RUN;
        end else if (cnt == SW_LAST) begin
          sel_ack_nxt  = 1'b1;
          err_nxt      = 1'b1;
          hold_low_nxt = ph_b;
          state_nxt    = RUN;
        end else if (!ph_b && old_low) begin
          ph_b_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state_nxt != state) begin
      cnt_nxt  = '0;
      ph_b_nxt = 1'b0;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ph_b     <= 1'b0;
      hold_low <= 1'b0;
      target   <= SEL_CLK10;
      cur_sel  <= SEL_CLK10;
      sel_ack  <= 1'b0;
      err      <= 1'b0;
      clk40_p0 <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ph_b     <= ph_b_nxt;
      hold_low <= hold_low_nxt;
      target   <= target_nxt;
      cur_sel  <= cur_sel_nxt;
      sel_ack  <= sel_ack_nxt;
      err      <= err_nxt;
      clk40_p0 <= clk40;
    end
  end

  clks_glitchless_mux u_mux (
    .clk        (clk),
    .rst        (rst),
    .clk10      (clk10),
    .clk20      (clk20),
    .clk40      (clk40),
    .cur_sel    (cur_sel),
    .target     (target),
    .force_low  (force_low),
    .clk_out    (clk_out),
    .old_low    (old_low),
    .target_low (target_low)
  );

endmodule

// File: tb/tb_clks_ctrl.sv
// Bench for clks_ctrl: a behavioural clks divider drives the clock inputs,
// directed requests push expected acknowledges into a queue, and a monitor
// pops and compares them whenever sel_ack appears.
module tb_clks_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, sel_valid;
  logic [1:0] sel_req;
  logic       sel_ack, clks_rst, clks_enb, clk_out, ready, busy, err;
  logic [1:0] cur_sel;
  logic       clk10, clk20, clk40;
  logic       tie10, tie40;

  always #5 clk = ~clk;

  // Divider model: periods 10/20/40, all rising on the first enabled edge.
  logic [7:0] dcnt;
  logic       m10, m20, m40;
  always @(posedge clk) begin
    if (clks_rst) begin
      dcnt <= 8'd0; m10 <= 1'b0; m20 <= 1'b0; m40 <= 1'b0;
    end else if (clks_enb) begin
      m10  <= (dcnt % 10) < 5;
      m20  <= (dcnt % 20) < 10;
      m40  <= (dcnt % 40) < 20;
      dcnt <= (dcnt == 8'd39) ? 8'd0 : dcnt + 8'd1;
    end
  end
  assign clk10 = tie10 ? 1'b1 : m10;
  assign clk20 = m20;
  assign clk40 = tie40 ? 1'b1 : m40;

  clks_ctrl #(.RST_CYCLES(8), .SETTLE_EDGES(2), .SW_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .sel_req(sel_req), .sel_valid(sel_valid), .sel_ack(sel_ack),
    .clk10(clk10), .clk20(clk20), .clk40(clk40),
    .clks_rst(clks_rst), .clks_enb(clks_enb), .clk_out(clk_out),
    .ready(ready), .busy(busy), .err(err), .cur_sel(cur_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic err; logic [1:0] sel; } ack_t;
  ack_t exp_q[$];
  ack_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every acknowledge must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sel_ack) begin
      check("ack_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ack_err", err, mon_e.err);
        check("ack_cur_sel", cur_sel, mon_e.sel);
      end
    end else if (err) begin
      check("err_needs_ack", sel_ack, 1);
    end
  end

  // Shortest clk_out high pulse seen while the divider is ready.
  int hi_run = 0;
  int min_hi = 1000;
  always @(negedge clk) begin
    if (clk_out) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run > 0 && ready && hi_run < min_hi) min_hi <= hi_run;
      hi_run <= 0;
    end
  end

  task automatic do_req(input logic [1:0] s, input logic e_err, input logic [1:0] e_sel,
                        output int lat, output int busy_n, output int lo);
    ack_t e;
    e.err = e_err;
    e.sel = e_sel;
    exp_q.push_back(e);
    sel_req = s; sel_valid = 1'b1;
    lat = 0; busy_n = 0; lo = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (clk_out) lo = 0; else lo++;
    end while (!sel_ack && lat < 200);
    sel_valid = 1'b0;
    check("req_ack_seen", sel_ack, 1);
  endtask

  task automatic run_hold(output int h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    h = 0;
    while (clks_rst && h < 300) begin
      h++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output int r);
    r = 0;
    while (!ready && r < 200) begin
      @(negedge clk);
      r++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  initial begin
    int h, r, lat, bn, lo, bad, k, p;
    logic pv, seen;
    rst = 1'b1; start = 1'b0; stop = 1'b0; sel_valid = 1'b0; sel_req = 2'd0;
    tie10 = 1'b0; tie40 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {clks_rst, clks_enb, clk_out, ready, busy, sel_ack, err}, 7'b1000000);
    check("reset_cur_sel", cur_sel, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_without_start", {clks_rst, clks_enb, ready}, 3'b100);

    // Power-up sequence
    run_hold(h);
    check("hold_cycles", h, 8);
    check("enb_after_hold", clks_enb, 1);
    wait_ready(r);
    check("ready_latency_41_45", (r >= 41 && r <= 45), 1);
    check("powerup_cur_sel", cur_sel, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      pv = clk10;
      @(negedge clk);
      if (clk_out !== pv) bad++;
    end
    check("follow_clk10_errors", bad, 0);

    // Same-source and illegal requests
    do_req(2'd0, 1'b0, 2'd0, lat, bn, lo);
    check("same_sel_latency", lat, 1);
    check("same_sel_busy_cycles", bn, 0);
    @(negedge clk);
    do_req(2'd3, 1'b1, 2'd0, lat, bn, lo);
    check("illegal_latency", lat, 1);
    check("illegal_keeps_cur_sel", cur_sel, 0);
    @(negedge clk);

    // Switch timeout: target clk40 never goes low
    tie40 = 1'b1;
    @(negedge clk);
    do_req(2'd2, 1'b1, 2'd0, lat, bn, lo);
    check("timeout_latency", lat, 65);
    check("timeout_busy_cycles", bn, 64);
    check("timeout_keeps_cur_sel", cur_sel, 0);
    check("timeout_back_in_run", {ready, busy}, 2'b10);
    tie40 = 1'b0;
    repeat (20) @(negedge clk);

    // Real switch clk10 -> clk40
    do_req(2'd2, 1'b0, 2'd2, lat, bn, lo);
    check("switch_busy_seen", bn > 0, 1);
    check("switch_cur_sel", cur_sel, 2);
    k = 0; seen = 1'b0;
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      if (clk_out) seen = 1'b1; else lo++;
    end
    check("switch_low_run_ge5", lo >= 5, 1);
    p = 0; pv = 1'b1; seen = 1'b0;
    while (p < 100 && !seen) begin
      @(negedge clk);
      p++;
      if (clk_out && !pv) seen = 1'b1;
      pv = clk_out;
    end
    check("clk40_period", p, 40);

    // Stop during phase B (target clk10 held high)
    tie10 = 1'b1;
    sel_req = 2'd0; sel_valid = 1'b1;
    bn = 0;
    repeat (45) begin
      @(negedge clk);
      if (busy) bn++;
    end
    check("busy_before_stop", bn, 45);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; sel_valid = 1'b0; tie10 = 1'b0;
    check("stop_outs", {clks_rst, clks_enb, clk_out, ready, busy, sel_ack, err}, 7'b1000000);
    check("stop_keeps_cur_sel", cur_sel, 2);
    repeat (3) @(negedge clk);

    // Restart re-runs HOLD, then stop beats a simultaneous request
    run_hold(h);
    check("rehold_cycles", h, 8);
    wait_ready(r);
    check("reready_latency_41_45", (r >= 41 && r <= 45), 1);
    check("restart_cur_sel", cur_sel, 2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      pv = clk40;
      @(negedge clk);
      if (clk_out !== pv) bad++;
    end
    check("follow_clk40_errors", bad, 0);
    stop = 1'b1; sel_req = 2'd0; sel_valid = 1'b1;
    @(negedge clk);
    stop = 1'b0; sel_valid = 1'b0;
    check("stop_beats_req", {clks_rst, ready, busy, sel_ack}, 4'b1000);
    repeat (3) @(negedge clk);

    // Reset in the middle of SETTLE
    run_hold(h);
    repeat (10) @(negedge clk);
    check("in_settle", {clks_enb, ready}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check("rst_settle_outs", {clks_rst, clks_enb, clk_out, ready, busy, sel_ack, err}, 7'b1000000);
    check("rst_settle_cur_sel", cur_sel, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("pending_acks", exp_q.size(), 0);
    check("min_high_pulse_ge5", min_hi >= 5, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clks_ctrl.md
Name: clks_ctrl

Overview:
- Sequences the clks divider through its lifecycle: power-up reset hold, enable, settle, run, stop.
- Qualifies the divider as ready once its outputs have settled.
- Drives one selected divided clock (clk10/clk20/clk40) onto clk_out, and switches between them glitch-free on a req/ack handshake.
- Sits between the top-level power/config logic and the clks instance. Everything runs in the fast clk domain; the divided clocks are sampled as data.

Parameters:
- RST_CYCLES, 8, cycles clks_rst is held high after start (range 1..255).
- SETTLE_EDGES, 2, clk40 rising edges counted after enable before ready asserts (range 1..15).
- SW_TIMEOUT, 64, max cycles in SWITCH before abort (must be > 40).

Ports:
- clk  in  1  fast clock, same as clks.clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; begin sequencing from IDLE.
- stop  in  1  level; return to IDLE from any state.
- sel_req  in  2  requested source: 0=clk10, 1=clk20, 2=clk40, 3=illegal.
- sel_valid  in  1  request valid; held by requester until sel_ack.
- sel_ack  out  1  one-cycle pulse closing a request.
- clk10  in  1  from clks.
- clk20  in  1  from clks.
- clk40  in  1  from clks.
- clks_rst  out  1  drives clks.rst.
- clks_enb  out  1  drives clks.enb.
- clk_out  out  1  registered, selected divided clock.
- ready  out  1  divider settled, clk_out valid.
- busy  out  1  high in SWITCH.
- err  out  1  one-cycle pulse: illegal sel_req or switch timeout.
- cur_sel  out  2  currently driven source.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: clks_rst=1; clks_enb=0, clk_out=0, ready=0, busy=0, sel_ack=0, err=0, cur_sel=0; state=IDLE; all counters 0.
- Divider facts used here: clk10/20/40 have periods of 10/20/40 clk cycles, and all three rise on the first enabled cycle after clks reset.
- IDLE: clks_rst=1, clks_enb=0, clk_out=0, ready=0. start=1 moves to HOLD next cycle.
- HOLD: clks_rst=1 for exactly RST_CYCLES cycles, counted by an 8-bit counter. On the cycle after the last, clks_rst=0 and clks_enb=1, and the state moves to SETTLE.
- SETTLE: a rising edge of clk40 is prev sample 0 and current sample 1. After SETTLE_EDGES such edges, move to RUN and set ready=1 on the same edge.
- RUN: clk_out <= the input selected by cur_sel, so clk_out lags the source by 1 cycle. Requests are handled as follows:
  - sel_valid with sel_req==cur_sel: sel_ack pulses next cycle; stay in RUN.
  - sel_valid with sel_req==3: sel_ack and err pulse together; no change.
  - Any other legal request: latch the target and move to SWITCH.
- SWITCH: busy=1; ready stays 1. It runs in three phases:
  - Phase A: keep following the old source until the old source samples 0. From then on, clk_out is forced to 0.
  - Phase B: wait until the target samples 0.
  - Phase C: set cur_sel=target, pulse sel_ack, return to RUN.
  - clk_out never produces a high pulse shorter than the shorter source's high phase.
  - Timeout: if SW_TIMEOUT cycles elapse, pulse err and sel_ack, keep the old cur_sel, and return to RUN.
- sel_valid is ignored (no ack) in IDLE/HOLD/SETTLE.
- stop: in any state other than IDLE, the next cycle is IDLE with all outputs at reset values, except that cur_sel is retained. It also aborts a SWITCH with no ack.
- Precedence: stop beats sel_valid and start in the same cycle. rst beats everything.
- start while not in IDLE is ignored. start and stop both high in IDLE: stay in IDLE.
- Counters saturate and clear on every state entry; there is no wrap-around.

Decomposition:
- Package clks_pkg holds:
  - SEL_CLK10/SEL_CLK20/SEL_CLK40/SEL_ILLEGAL constants;
  - the state enum IDLE/HOLD/SETTLE/RUN/SWITCH (3 bits);
  - parameter range-check constants.
- One sub-module, clks_glitchless_mux: takes the 3 clock samples, cur_sel, target and a force_low input; provides the registered clk_out and old_low/target_low flags. The FSM, counters and handshake stay in clks_ctrl.

Test Plan:
- Power-up: rst then start=1 -> clks_rst high for 8 cycles, clks_enb rises the next cycle, ready rises between 41 and 45 cycles after clks_enb (second clk40 edge); cur_sel=0 and clk_out follows clk10 delayed 1 cycle.
- Switch 0->2 with sel_valid held -> busy high, clk_out low for at least 5 cycles with no short pulse; sel_ack is a single pulse, cur_sel=2, and clk_out then has period 40.
- Same-sel and illegal requests in RUN: sel_req=0 -> sel_ack next cycle, no busy. sel_req=3 -> sel_ack+err same cycle, cur_sel unchanged.
- Stop mid-SWITCH: assert stop during phase B -> next cycle IDLE, clks_rst=1, clks_enb=0, ready=0, no sel_ack, cur_sel holds the old value. Re-start re-runs HOLD.
- Timeout: tie clk40 to 1 in the bench model, request sel=2 -> after 64 cycles err+sel_ack pulse, cur_sel unchanged, RUN resumed.
- Simultaneous stop+sel_valid in RUN -> stop wins, no ack. rst mid-SETTLE -> all outputs at reset values next cycle.
